// File: rtl/multi_channel_signal_generator.sv
// Multi-voice tone/noise generator. Each voice has its own divider, phase, LFSR and mode.
// A first-order delta-sigma mixer folds the voices into one registered 1-bit output.
module multi_channel_signal_generator #(
  parameter int CHANNELS   = 3,
  parameter int ADDR_WIDTH = 4,
  parameter int DIV_WIDTH  = 12
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  write_strobe,
  input  logic [ADDR_WIDTH-1:0] address,
  input  logic [4:0]            data,
  output logic                  signal_out,
  output logic [CHANNELS-1:0]   channel_out,
  output logic [6:0]            debug
);

  localparam int CH_W  = ADDR_WIDTH - 2;
  localparam int ACC_W = $clog2(2 * CHANNELS);
  localparam logic [CH_W:0]          CH_LIMIT = (CH_W + 1)'(CHANNELS);
  localparam logic [DIV_WIDTH-1:0]   HI_MASK  = ~DIV_WIDTH'(10'h3FF);

  // Write port: write_strobe is asynchronous. One write fires on the first cycle the
  // synchronised strobe (s2) is high while its delayed copy (s3) is still low.
  logic s1_q, s2_q, s3_q;
  logic [3:0] wcount_q, wcount_d;

  logic [DIV_WIDTH-1:0] div_q     [CHANNELS];
  logic [DIV_WIDTH-1:0] div_d     [CHANNELS];
  logic [2:0]           ctrl_q    [CHANNELS];
  logic [2:0]           ctrl_d    [CHANNELS];
  logic [DIV_WIDTH-1:0] counter_q [CHANNELS];
  logic [DIV_WIDTH-1:0] counter_d [CHANNELS];
  logic [2:0]           phase_q   [CHANNELS];
  logic [2:0]           phase_d   [CHANNELS];
  logic [14:0]          lfsr_q    [CHANNELS];
  logic [14:0]          lfsr_d    [CHANNELS];
  logic [CHANNELS-1:0]  step_c;

  logic [ACC_W-1:0] acc_q, acc_d, level, sum;
  logic             sig_q, sig_d;

  logic            wr_fire, wr_ok;
  logic [CH_W-1:0] wr_ch;
  logic [1:0]      wr_idx;

  assign wr_fire = s2_q & ~s3_q;
  assign wr_ch   = address[ADDR_WIDTH-1:2];
  assign wr_idx  = address[1:0];
  assign wr_ok   = wr_fire && ({1'b0, wr_ch} < CH_LIMIT);

  always_comb begin
    wcount_d = wcount_q;
    for (int c = 0; c < CHANNELS; c++) begin
      div_d[c]  = div_q[c];
      ctrl_d[c] = ctrl_q[c];
    end
    if (wr_ok) begin
      wcount_d = wcount_q + 4'd1;
      for (int c = 0; c < CHANNELS; c++) begin
        if (wr_ch == CH_W'(c)) begin
          case (wr_idx)
            2'd0:    div_d[c][4:0] = data;
            2'd1:    div_d[c][9:5] = data;
            2'd2:    div_d[c] = (div_q[c] & ~HI_MASK) | ((DIV_WIDTH'(data) << 10) & HI_MASK);
            default: ctrl_d[c] = data[2:0];
          endcase
        end
      end
    end
  end

  // Channel cores run from the registered div/ctrl, so a same-edge write only takes
  // effect on the following cycle.
  always_comb begin
    step_c      = '0;
    channel_out = '0;
    for (int c = 0; c < CHANNELS; c++) begin
      counter_d[c] = counter_q[c];
      phase_d[c]   = phase_q[c];
      lfsr_d[c]    = lfsr_q[c];
      if (!ctrl_q[c][0]) begin
        counter_d[c] = '0;
        phase_d[c]   = '0;
      end else if (div_q[c] != '0) begin
        if (counter_q[c] >= div_q[c]) begin
          counter_d[c] = '0;
          step_c[c]    = 1'b1;
        end else begin
          counter_d[c] = counter_q[c] + DIV_WIDTH'(1);
        end
      end
      if (step_c[c]) begin
        phase_d[c] = phase_q[c] + 3'd1;
        lfsr_d[c]  = {lfsr_q[c][13:0], lfsr_q[c][14] ^ lfsr_q[c][13]};
      end
      if (ctrl_q[c][0]) begin
        case (ctrl_q[c][2:1])
          2'b00:   channel_out[c] = phase_q[c][2];
          2'b01:   channel_out[c] = (phase_q[c][2:1] == 2'b11);
          2'b10:   channel_out[c] = lfsr_q[c][0];
          default: channel_out[c] = (phase_q[c] == 3'd7);
        endcase
      end
    end
  end

  always_comb begin
    level = '0;
    for (int c = 0; c < CHANNELS; c++) begin
      level = level + ACC_W'(channel_out[c]);
    end
    sum   = acc_q + level;
    sig_d = 1'b0;
    acc_d = sum;
    if (sum >= ACC_W'(CHANNELS)) begin
      sig_d = 1'b1;
      acc_d = sum - ACC_W'(CHANNELS);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_q     <= 1'b0;
      s2_q     <= 1'b0;
      s3_q     <= 1'b0;
      wcount_q <= '0;
      acc_q    <= '0;
      sig_q    <= 1'b0;
      for (int c = 0; c < CHANNELS; c++) begin
        div_q[c]     <= '0;
        ctrl_q[c]    <= '0;
        counter_q[c] <= '0;
        phase_q[c]   <= '0;
        lfsr_q[c]    <= 15'h0001;
      end
    end else begin
      s1_q     <= write_strobe;
      s2_q     <= s1_q;
      s3_q     <= s2_q;
      wcount_q <= wcount_d;
      acc_q    <= acc_d;
      sig_q    <= sig_d;
      for (int c = 0; c < CHANNELS; c++) begin
        div_q[c]     <= div_d[c];
        ctrl_q[c]    <= ctrl_d[c];
        counter_q[c] <= counter_d[c];
        phase_q[c]   <= phase_d[c];
        lfsr_q[c]    <= lfsr_d[c];
      end
    end
  end

  assign signal_out = sig_q;
  assign debug      = {wcount_q, phase_q[0]};

endmodule
